morse_decoder_fifo: RTL and testbench

Parametrised successor to the morse detector datapath. Accumulates one-cycle dot/dash pulses into a symbol pattern and decodes it to uppercase ASCII on a character or word gap. Decoded bytes go into an internal FIFO with a valid/ready output handshake, so a slow consumer (UART/display) can apply backpressure. Sits between the key-timing front end and the character sink.

---
 rtl/morse_decoder_fifo.sv | 148 ++++++++++++++
 tb/tb_morse_decoder_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/morse_decoder_fifo.sv
// morse_decoder_fifo: accumulates dot/dash pulses, decodes to ASCII on gaps, queues bytes in a show-ahead FIFO
//   clk, rst (async, active-low)
//   dot_inp, dash_inp, char_space_inp, word_space_inp : one-cycle key-timing pulses
//   sout/sout_valid/sout_ready : decoded byte stream with backpressure
//   fifo_count, busy, overflow : status
module morse_decoder_fifo #(
  parameter int         DEPTH       = 8,
  parameter int         MAX_SYMBOLS = 6,
  parameter logic [7:0] ERR_CHAR    = 8'h3F
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dot_inp,
  input  logic                   dash_inp,
  input  logic                   char_space_inp,
  input  logic                   word_space_inp,
  output logic [7:0]             sout,
  output logic                   sout_valid,
  input  logic                   sout_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, PUSH_SPACE} state_t;
  state_t state, state_nx;
  logic [MAX_SYMBOLS-1:0] pat;
  logic [3:0] len;
  logic err;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [7:0] last;
  logic sym, both, gap, pending, push, pop, wr;
  logic [7:0] dec, push_byte;
  // key is {length, pattern right-aligned}, dot=0, dash=1, first symbol most significant
  function automatic logic [7:0] decode(input logic [3:0] l, input logic [7:0] c);
    logic [7:0] d;
    case ({l, c})
      12'h201: d = 8'h41;
      12'h408: d = 8'h42;
      12'h40A: d = 8'h43;
      12'h304: d = 8'h44;
      12'h100: d = 8'h45;
      12'h402: d = 8'h46;
      12'h306: d = 8'h47;
      12'h400: d = 8'h48;
      12'h200: d = 8'h49;
      12'h407: d = 8'h4A;
      12'h305: d = 8'h4B;
      12'h404: d = 8'h4C;
      12'h203: d = 8'h4D;
      12'h202: d = 8'h4E;
      12'h307: d = 8'h4F;
      12'h406: d = 8'h50;
      12'h40D: d = 8'h51;
      12'h302: d = 8'h52;
      12'h300: d = 8'h53;
      12'h101: d = 8'h54;
      12'h301: d = 8'h55;
      12'h401: d = 8'h56;
      12'h303: d = 8'h57;
      12'h409: d = 8'h58;
      12'h40B: d = 8'h59;
      12'h40C: d = 8'h5A;
      12'h51F: d = 8'h30;
      12'h50F: d = 8'h31;
      12'h507: d = 8'h32;
      12'h503: d = 8'h33;
      12'h501: d = 8'h34;
      12'h500: d = 8'h35;
      12'h510: d = 8'h36;
      12'h518: d = 8'h37;
      12'h51C: d = 8'h38;
      12'h51E: d = 8'h39;
      12'h615: d = MAX_SYMBOLS >= 6 ? 8'h2E : ERR_CHAR;
      12'h633: d = MAX_SYMBOLS >= 6 ? 8'h2C : ERR_CHAR;
      12'h60C: d = MAX_SYMBOLS >= 6 ? 8'h3F : ERR_CHAR;
      default: d = ERR_CHAR;
    endcase
    return d;
  endfunction
  assign sym = dot_inp ^ dash_inp;
  assign both = dot_inp & dash_inp;
  assign busy = len != 4'd0;
  // a lone error (e.g. dot+dash collision) still owes the sink an ERR_CHAR
  assign pending = busy | err;
  assign gap = state == IDLE && (word_space_inp || char_space_inp);
  assign dec = err ? ERR_CHAR : decode(len, 8'(pat));
  always_comb begin
    state_nx = IDLE;
    push = 1'b0;
    push_byte = 8'h20;
    if (state == PUSH_SPACE) push = 1'b1;
    else if (word_space_inp) begin
      push = 1'b1;
      push_byte = pending ? dec : 8'h20;
      state_nx = pending ? PUSH_SPACE : IDLE;
    end else if (char_space_inp) begin
      push = pending;
      push_byte = dec;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // a symbol coinciding with a gap starts the next character
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pat <= '0;
      len <= 4'd0;
      err <= 1'b0;
    end else if (gap) begin
      pat <= {{(MAX_SYMBOLS-1){1'b0}}, dash_inp & ~dot_inp};
      len <= {3'b000, sym};
      err <= both;
    end else if (both) err <= 1'b1;
    else if (sym) begin
      if (len == 4'(MAX_SYMBOLS)) err <= 1'b1;
      else begin
        pat <= {pat[MAX_SYMBOLS-2:0], dash_inp};
        len <= len + 4'd1;
      end
    end
  assign sout_valid = fifo_count != '0;
  assign pop = sout_valid & sout_ready;
  // count never exceeds DEPTH, so its MSB alone means full
  assign wr = push & (~fifo_count[AW] | pop);
  assign sout = sout_valid ? mem[rp] : last;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= push_byte;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      last <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) begin
        rp <= rp + AW'(1);
        last <= mem[rp];
      end
      fifo_count <= wr && !pop ? fifo_count + CW'(1) : !wr && pop ? fifo_count - CW'(1) : fifo_count;
      if (push && !wr) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_morse_decoder_fifo.sv
// tb_morse_decoder_fifo: directed stimulus with a queue scoreboard and a decoupled output monitor
module tb_morse_decoder_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dot_inp = 1'b0, dash_inp = 1'b0, char_space_inp = 1'b0, word_space_inp = 1'b0;
  logic sout_ready = 1'b0;
  logic [7:0] sout;
  logic sout_valid, busy, overflow;
  logic [3:0] fifo_count;
  logic [7:0] exp_q [$];
  logic [7:0] e;
  int vectors = 0;
  int miscompares = 0;

  morse_decoder_fifo dut (
    .clk(clk), .rst(rst),
    .dot_inp(dot_inp), .dash_inp(dash_inp),
    .char_space_inp(char_space_inp), .word_space_inp(word_space_inp),
    .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst && sout_valid && sout_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL out: unexpected byte %02h, none expected", sout);
      end else begin
        e = exp_q.pop_front();
        if (sout !== e) begin
          miscompares++;
          $display("FAIL out: got %02h expected %02h", sout, e);
        end
      end
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic d, input logic da, input logic c, input logic w);
    dot_inp = d; dash_inp = da; char_space_inp = c; word_space_inp = w;
    @(posedge clk); #1;
    dot_inp = 0; dash_inp = 0; char_space_inp = 0; word_space_inp = 0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) pulse(s[i] == "." ? 1'b1 : 1'b0, s[i] == "-" ? 1'b1 : 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chr(input string s, input logic [7:0] b);
    send(s);
    exp_q.push_back(b);
    pulse(0, 0, 1, 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || sout_valid); i++) begin
      @(posedge clk); #1;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_sout", sout, 8'h00);
    check("rst_valid", sout_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    // SOS
    sout_ready = 1'b1;
    chr("...", 8'h53);
    chr("---", 8'h4F);
    send("...");
    check("busy_mid", busy, 1);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h20);
    pulse(0, 0, 0, 1);
    drain("sos_drain");
    check("sos_busy", busy, 0);
    check("sos_overflow", overflow, 0);
    // invalid, over-length, then recovery
    chr("..--", 8'h3F);
    chr(".......", 8'h3F);
    chr(".-", 8'h41);
    chr(".-.-.-", 8'h2E);
    chr("--..--", 8'h2C);
    chr("-----", 8'h30);
    chr("--..", 8'h5A);
    drain("err_drain");
    // collisions: dot+dash, then a dash riding on char_space
    exp_q.push_back(8'h3F);
    pulse(1, 1, 0, 0);
    pulse(0, 0, 1, 0);
    send("-.");
    exp_q.push_back(8'h4E);
    pulse(0, 1, 1, 0);
    exp_q.push_back(8'h54);
    pulse(0, 0, 1, 0);
    drain("sim_drain");
    // full FIFO with simultaneous pop and push
    sout_ready = 1'b0;
    repeat (8) chr(".", 8'h45);
    check("full_count", fifo_count, 8);
    send("-.-");
    sout_ready = 1'b1;
    exp_q.push_back(8'h4B);
    pulse(0, 0, 1, 0);
    check("pushpop_count", fifo_count, 8);
    check("pushpop_overflow", overflow, 0);
    drain("pushpop_drain");
    // backpressure with overflow
    sout_ready = 1'b0;
    repeat (8) chr(".", 8'h45);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    check("bp_count", fifo_count, 8);
    check("bp_overflow", overflow, 1);
    check("bp_head", sout, 8'h45);
    sout_ready = 1'b1;
    drain("bp_drain");
    check("bp_empty", fifo_count, 0);
    check("bp_sticky", overflow, 1);
    check("bp_hold", sout, 8'h45);
    // reset during PUSH_SPACE and mid-character
    sout_ready = 1'b0;
    send("..");
    pulse(0, 0, 0, 1);
    rst = 1'b0;
    #1;
    check("r6_sout", sout, 8'h00);
    check("r6_valid", sout_valid, 0);
    check("r6_count", fifo_count, 0);
    check("r6_busy", busy, 0);
    check("r6_overflow", overflow, 0);
    @(posedge clk); #1 rst = 1'b1;
    send(".");
    check("r6_busy_char", busy, 1);
    rst = 1'b0;
    #1 check("r6_busy_clr", busy, 0);
    @(posedge clk); #1 rst = 1'b1;
    sout_ready = 1'b1;
    pulse(0, 0, 1, 0);
    repeat (3) begin
      check("r6_nopush", sout_valid, 0);
      @(posedge clk); #1;
    end
    check("r6_final_count", fifo_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
